// File: rtl/ser2par_align_if.sv
// ser2par_align_if
//   Bundles the serial line input and the recovered parallel word outputs of
//   ser2par_align. The bit clock and reset stay plain module ports.
//   Signals:
//     data_in    - serial line bit, one per bit clock
//     RXPOL      - line polarity select (1 = invert data_in)
//     data_out   - last complete word, first-received bit at [0]
//     data_valid - one-cycle strobe marking a new data_out
//     aligned    - word boundary locked
//     comma_det  - one-cycle strobe, comma seen on a word boundary
//   Modports: slave = deserializer side, master = line/consumer side.
interface ser2par_align_if #(
  parameter int WIDTH = 10
);
  logic             data_in;
  logic             RXPOL;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             aligned;
  logic             comma_det;

  modport slave (
    input  data_in, RXPOL,
    output data_out, data_valid, aligned, comma_det
  );

  modport master (
    output data_in, RXPOL,
    input  data_out, data_valid, aligned, comma_det
  );
endinterface

// File: rtl/ser2par_align.sv
// ser2par_align
//   Serial-to-parallel converter with comma-based word alignment.
//   Build option: define SER2PAR_ALIGN_COMMA_EN to enable the comma hunt /
//   lock machine. Without it the word boundary free-runs from reset release
//   and the block always reports aligned.
//   Ports:
//     CRC_CKL - receive bit clock, rising edge active
//     RESET_L - asynchronous active-low reset
//     bus     - ser2par_align_if.slave (data_in, RXPOL, data_out,
//               data_valid, aligned, comma_det)
//
//   state  | meaning
//   HUNT   | searching every bit position for COMMA / ~COMMA
//   LOCKED | boundary fixed, words emitted every WIDTH bits
module ser2par_align #(
  parameter int               WIDTH   = 10,
  parameter logic [WIDTH-1:0] COMMA   = 10'b0011111010,
  parameter int               MAX_ERR = 4
) (
  input  logic           CRC_CKL,
  input  logic           RESET_L,
  ser2par_align_if.slave bus
);
  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // A constant comma pattern would lock on an idle line.
  if (WIDTH < 4 || WIDTH > 32 || MAX_ERR < 1 || MAX_ERR > 15 ||
      COMMA == '0 || COMMA == '1) begin : g_param_check
    $error("ser2par_align: illegal parameter set");
  end

  logic             line_bit;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             at_last;
  logic             load_d;
  logic             valid_q;

  assign line_bit = bus.data_in ^ bus.RXPOL;
  assign sr_next  = {line_bit, sr[WIDTH-1:1]};
  assign at_last  = (bit_cnt == LAST_BIT);

  always_ff @(posedge CRC_CKL or negedge RESET_L) begin
    if (!RESET_L) begin
      sr      <= '0;
      data_q  <= '0;
      bit_cnt <= '0;
      valid_q <= 1'b0;
    end else begin
      sr      <= sr_next;
      bit_cnt <= cnt_d;
      valid_q <= load_d;
      if (load_d) data_q <= sr_next;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;

`ifdef SER2PAR_ALIGN_COMMA_EN
  localparam logic [3:0] ERR_LIMIT = 4'(MAX_ERR);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [3:0] err_q, err_d;
  logic       comma_d, comma_q;
  logic       match;

  // Both running-disparity forms of the comma are accepted.
  assign match = (sr_next == COMMA) || (sr_next == ~COMMA);

  always_ff @(posedge CRC_CKL or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q <= HUNT;
      err_q   <= '0;
      comma_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      comma_q <= comma_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = bit_cnt;
    load_d  = 1'b0;
    comma_d = 1'b0;
    case (state_q)
      HUNT: begin
        if (match) begin
          load_d  = 1'b1;
          comma_d = 1'b1;
          cnt_d   = '0;
          err_d   = '0;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        cnt_d = at_last ? '0 : bit_cnt + 1'b1;
        if (at_last) begin
          load_d = 1'b1;
          if (match) begin
            comma_d = 1'b1;
            err_d   = '0;
          end
        end else if (match) begin
          // Reaching the limit drops lock at once; the counter never
          // exceeds ERR_LIMIT, so it cannot wrap.
          if (err_q >= ERR_LIMIT - 4'd1) begin
            err_d   = ERR_LIMIT;
            state_d = HUNT;
          end else begin
            err_d = err_q + 4'd1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  assign bus.aligned   = (state_q == LOCKED);
  assign bus.comma_det = comma_q;
`else
  logic aligned_q;

  always_comb begin
    cnt_d  = at_last ? '0 : bit_cnt + 1'b1;
    load_d = at_last;
  end

  // Boundary is defined by reset release, so alignment is claimed from the
  // first clock after it.
  always_ff @(posedge CRC_CKL or negedge RESET_L) begin
    if (!RESET_L) aligned_q <= 1'b0;
    else          aligned_q <= 1'b1;
  end

  assign bus.aligned   = aligned_q;
  assign bus.comma_det = 1'b0;
`endif
endmodule

// File: tb/tb_ser2par_align.sv
// tb_ser2par_align
//   Directed self-checking bench for ser2par_align (WIDTH=10, defaults).
//   Covers the comma hunt/lock build when SER2PAR_ALIGN_COMMA_EN is defined,
//   otherwise the free-running build.
module tb_ser2par_align;
  logic CRC_CKL = 1'b0;
  logic RESET_L;
  int   checks   = 0;
  int   failures = 0;
  int   ndv;
  int   ncd;

  ser2par_align_if #(.WIDTH(10)) bus();

  ser2par_align #(.WIDTH(10)) dut (
    .CRC_CKL (CRC_CKL),
    .RESET_L (RESET_L),
    .bus     (bus)
  );

  always #5 CRC_CKL = ~CRC_CKL;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one effective bit; the line carries b^inv and RXPOL=inv.
  task automatic bit_out(input logic b, input logic inv);
    @(negedge CRC_CKL);
    bus.data_in = b ^ inv;
    bus.RXPOL   = inv;
    @(posedge CRC_CKL);
    #1;
  endtask

  // Send a word bit0 first, checking the strobes after every bit.
  task automatic word_chk(input logic [9:0] w, input logic inv,
                          input logic dv_last, input logic cd_last, input string tag);
    for (int i = 0; i < 10; i++) begin
      bit_out(w[i], inv);
      chk({tag, "_dv"}, bus.data_valid, (i == 9) ? dv_last : 1'b0);
      chk({tag, "_cd"}, bus.comma_det,  (i == 9) ? cd_last : 1'b0);
    end
  endtask

  // Send a word bit0 first, counting strobes.
  task automatic word_cnt(input logic [9:0] w, input logic inv,
                          output int dv_n, output int cd_n);
    dv_n = 0;
    cd_n = 0;
    for (int i = 0; i < 10; i++) begin
      bit_out(w[i], inv);
      if (bus.data_valid === 1'b1) dv_n++;
      if (bus.comma_det === 1'b1) cd_n++;
    end
  endtask

  task automatic assert_reset();
    RESET_L     = 1'b0;
    bus.data_in = 1'b0;
    bus.RXPOL   = 1'b0;
    repeat (2) @(posedge CRC_CKL);
    #1;
  endtask

  // Release between a rising edge and the next drive point.
  task automatic release_reset();
    @(posedge CRC_CKL);
    #2;
    RESET_L = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"},    bus.data_out,   32'h0);
    chk({tag, "_dv"},      bus.data_valid, 32'h0);
    chk({tag, "_cd"},      bus.comma_det,  32'h0);
    chk({tag, "_aligned"}, bus.aligned,    32'h0);
  endtask

  initial begin
    logic [2:0] pre;
    pre = 3'b011;            // sent bit0 first: 1,1,0
    assert_reset();
    chk_zero("rst");

`ifdef SER2PAR_ALIGN_COMMA_EN
    // Comma after a short prefix, then a data word.
    release_reset();
    for (int i = 0; i < 3; i++) begin
      bit_out(pre[i], 1'b0);
      chk("pre_dv", bus.data_valid, 32'h0);
      chk("pre_cd", bus.comma_det, 32'h0);
      chk("pre_aligned", bus.aligned, 32'h0);
    end
    word_chk(10'h0FA, 1'b0, 1'b1, 1'b1, "comma");
    chk("comma_data", bus.data_out, 32'h0FA);
    chk("comma_aligned", bus.aligned, 32'h1);
    word_chk(10'h155, 1'b0, 1'b1, 1'b0, "word1");
    chk("word1_data", bus.data_out, 32'h155);

    // Inverted-disparity comma on a boundary.
    word_chk(10'h305, 1'b0, 1'b1, 1'b1, "ncomma");
    chk("ncomma_data", bus.data_out, 32'h305);
    chk("ncomma_err", dut.err_q, 32'h0);
    chk("ncomma_aligned", bus.aligned, 32'h1);

    // Same stream with inverted line and RXPOL=1.
    assert_reset();
    chk_zero("rst2");
    release_reset();
    for (int i = 0; i < 3; i++) begin
      bit_out(pre[i], 1'b1);
      chk("ipre_dv", bus.data_valid, 32'h0);
    end
    word_chk(10'h0FA, 1'b1, 1'b1, 1'b1, "icomma");
    chk("icomma_data", bus.data_out, 32'h0FA);
    chk("icomma_aligned", bus.aligned, 32'h1);
    word_chk(10'h155, 1'b1, 1'b1, 1'b0, "iword1");
    chk("iword1_data", bus.data_out, 32'h155);

    // Four commas shifted by 3 bits drop lock.
    assert_reset();
    release_reset();
    word_chk(10'h0FA, 1'b0, 1'b1, 1'b1, "lock");
    word_chk(10'h155, 1'b0, 1'b1, 1'b0, "lockw");
    for (int i = 0; i < 3; i++) bit_out(pre[i], 1'b0);
    for (int k = 0; k < 4; k++) begin
      word_cnt(10'h0FA, 1'b0, ndv, ncd);
      chk("shift_dv", ndv, 32'd1);
      chk("shift_cd", ncd, 32'd0);
      chk("shift_err", dut.err_q, k + 1);
      chk("shift_aligned", bus.aligned, (k < 3) ? 32'h1 : 32'h0);
    end
    word_cnt(10'h155, 1'b0, ndv, ncd);
    chk("drop_dv", ndv, 32'd0);
    chk("drop_cd", ncd, 32'd0);
    word_cnt(10'h2AA, 1'b0, ndv, ncd);
    chk("drop2_dv", ndv, 32'd0);
    chk("drop_aligned", bus.aligned, 32'h0);
    word_chk(10'h0FA, 1'b0, 1'b1, 1'b1, "relock");
    chk("relock_data", bus.data_out, 32'h0FA);
    chk("relock_aligned", bus.aligned, 32'h1);
    chk("relock_err", dut.err_q, 32'h0);

    // Reset at bit 5 of a locked word.
    for (int i = 0; i < 5; i++) bit_out(1'b1, 1'b0);
    RESET_L = 1'b0;
    #1;
    chk_zero("midrst");
    bus.data_in = 1'b0;
    release_reset();
    word_cnt(10'h155, 1'b0, ndv, ncd);
    chk("postrst_dv", ndv, 32'd0);
    chk("postrst_aligned", bus.aligned, 32'h0);
    word_chk(10'h0FA, 1'b0, 1'b1, 1'b1, "postrst_comma");
    chk("postrst_data", bus.data_out, 32'h0FA);
    chk("postrst_aligned2", bus.aligned, 32'h1);
`else
    // Free-running boundary: words at cycles 10 and 20 after release.
    release_reset();
    word_chk(10'h2AA, 1'b0, 1'b1, 1'b0, "fr_w1");
    chk("fr_w1_data", bus.data_out, 32'h2AA);
    chk("fr_aligned", bus.aligned, 32'h1);
    word_chk(10'h155, 1'b0, 1'b1, 1'b0, "fr_w2");
    chk("fr_w2_data", bus.data_out, 32'h155);

    // A comma is just data here; inverted line with RXPOL=1.
    word_chk(10'h0FA, 1'b1, 1'b1, 1'b0, "fr_inv");
    chk("fr_inv_data", bus.data_out, 32'h0FA);
    bit_out(1'b1, 1'b0);
    chk("fr_hold_data", bus.data_out, 32'h0FA);
    chk("fr_hold_dv", bus.data_valid, 32'h0);

    // Partial word discarded by a reset pulse.
    for (int i = 0; i < 4; i++) bit_out(1'b1, 1'b0);
    RESET_L = 1'b0;
    #1;
    chk_zero("fr_midrst");
    release_reset();
    word_chk(10'h305, 1'b0, 1'b1, 1'b0, "fr_post");
    chk("fr_post_data", bus.data_out, 32'h305);
    chk("fr_post_aligned", bus.aligned, 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
